// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the SEQ sequencer: instruction codes, status
// codes, stage states and memory-class decode helpers.
package y86_pkg;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK,
    ST_PCUPD,
    ST_HALT
  } stage_t;

  function automatic logic is_mem_read(input logic [3:0] ic);
    return (ic == I_MRMOV) || (ic == I_RET) || (ic == I_POP);
  endfunction

  function automatic logic is_mem_write(input logic [3:0] ic);
    return (ic == I_RMMOV) || (ic == I_CALL) || (ic == I_PUSH);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts data-memory wait cycles; timeout fires on the cycle whose increment
// would reach MEM_TIMEOUT.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign timeout = en && (count_reg == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/seq_stage_controller.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ datapath; owns CC, status
// and the retired-instruction counter.
module seq_stage_controller
  import y86_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             alu_zf,
  input  logic             alu_sf,
  input  logic             alu_of,
  input  logic             mem_ready,
  input  logic             dmem_error,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             writeback_en,
  output logic             pc_en,
  output logic             mem_read,
  output logic             mem_write,
  output logic             set_cc,
  output logic [2:0]       cc,
  output logic [2:0]       stat,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] instr_count
);

  stage_t           state_reg, state_next;
  logic [2:0]       stat_reg, stat_next;
  logic [2:0]       cc_reg;
  logic [3:0]       icode_q;
  logic [CNT_W-1:0] instr_count_reg;
  logic             timer_clr, timer_en, timeout;

  assign timer_en  = (state_reg == ST_MEMORY) && !mem_ready;
  assign timer_clr = (state_reg != ST_MEMORY) || mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .timeout (timeout)
  );

  always_comb begin
    state_next = state_reg;
    stat_next  = stat_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        // Fault priority: address fault, then illegal instruction, then halt.
        if (imem_error) begin
          stat_next  = STAT_ADR;
          state_next = ST_HALT;
        end else if (!instr_valid) begin
          stat_next  = STAT_INS;
          state_next = ST_HALT;
        end else if (icode == I_HALT) begin
          stat_next  = STAT_HLT;
          state_next = ST_HALT;
        end else begin
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: state_next = ST_EXECUTE;
      ST_EXECUTE: begin
        if (is_mem_read(icode_q) || is_mem_write(icode_q)) state_next = ST_MEMORY;
        else state_next = ST_WRITEBACK;
      end
      ST_MEMORY: begin
        // A ready response takes precedence over a coincident timeout.
        if (mem_ready) begin
          if (dmem_error) begin
            stat_next  = STAT_ADR;
            state_next = ST_HALT;
          end else begin
            state_next = ST_WRITEBACK;
          end
        end else if (timeout) begin
          stat_next  = STAT_ADR;
          state_next = ST_HALT;
        end
      end
      ST_WRITEBACK: state_next = ST_PCUPD;
      ST_PCUPD:     state_next = ST_FETCH;
      ST_HALT:      state_next = ST_HALT;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      stat_reg        <= STAT_AOK;
      cc_reg          <= 3'b100;
      icode_q         <= 4'h0;
      instr_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      stat_reg  <= stat_next;
      if (state_reg == ST_FETCH) icode_q <= icode;
      if (state_reg == ST_EXECUTE && icode_q == I_OPQ) cc_reg <= {alu_zf, alu_sf, alu_of};
      if (state_reg == ST_PCUPD) instr_count_reg <= instr_count_reg + CNT_W'(1);
    end
  end

  always_comb begin
    fetch_en     = 1'b0;
    decode_en    = 1'b0;
    execute_en   = 1'b0;
    memory_en    = 1'b0;
    writeback_en = 1'b0;
    pc_en        = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    set_cc       = 1'b0;
    case (state_reg)
      ST_FETCH:     fetch_en = 1'b1;
      ST_DECODE:    decode_en = 1'b1;
      ST_EXECUTE: begin
        execute_en = 1'b1;
        set_cc     = (icode_q == I_OPQ);
      end
      ST_MEMORY: begin
        memory_en = 1'b1;
        mem_read  = is_mem_read(icode_q);
        mem_write = is_mem_write(icode_q);
      end
      ST_WRITEBACK: writeback_en = 1'b1;
      ST_PCUPD:     pc_en = 1'b1;
      default: ;
    endcase
  end

  assign cc          = cc_reg;
  assign stat        = stat_reg;
  assign halted      = (state_reg == ST_HALT);
  assign busy        = (state_reg != ST_IDLE) && (state_reg != ST_HALT);
  assign instr_count = instr_count_reg;

endmodule

// File: tb/tb_seq_stage_controller.sv
// Transaction-level bench for seq_stage_controller: each instruction is
// expanded into its expected stage sequence and compared cycle by cycle.
module tb_seq_stage_controller;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  icode = 4'h1;
  logic        instr_valid = 1'b1;
  logic        imem_error = 1'b0;
  logic        alu_zf = 1'b0, alu_sf = 1'b0, alu_of = 1'b0;
  logic        mem_ready = 1'b0;
  logic        dmem_error = 1'b0;
  logic        fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en;
  logic        mem_read, mem_write, set_cc, halted, busy;
  logic [2:0]  cc, stat;
  logic [31:0] instr_count;

  int errors = 0;
  int checks = 0;

  logic [2:0]  m_cc;
  logic [2:0]  m_stat;
  logic [31:0] m_cnt;
  bit          m_halt;

  always #5 clk = ~clk;

  seq_stage_controller #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode), .instr_valid(instr_valid),
    .imem_error(imem_error), .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of),
    .mem_ready(mem_ready), .dmem_error(dmem_error),
    .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
    .memory_en(memory_en), .writeback_en(writeback_en), .pc_en(pc_en),
    .mem_read(mem_read), .mem_write(mem_write), .set_cc(set_cc), .cc(cc),
    .stat(stat), .halted(halted), .busy(busy), .instr_count(instr_count)
  );

  logic [10:0] dut_vec;
  assign dut_vec = {fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en,
                    mem_read, mem_write, set_cc, busy, halted};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // stg: 0..5 = fetch..pcupd, 6 = halt, 7 = idle
  function automatic logic [10:0] exp_vec(input int stg, input logic [3:0] ic);
    logic [10:0] v;
    v = '0;
    if (stg <= 5) begin
      v[10 - stg] = 1'b1;
      v[1] = 1'b1;
    end
    if (stg == 2) v[2] = (ic == 4'h6);
    if (stg == 3) begin
      v[4] = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
      v[3] = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
    end
    if (stg == 6) v[0] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".cc"}, 64'(cc), 64'(m_cc));
    check({tag, ".stat"}, 64'(stat), 64'(m_stat));
    check({tag, ".cnt"}, 64'(instr_count), 64'(m_cnt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    start = 1'b0;
    step();
    rst = 1'b0;
    m_cc = 3'b100;
    m_stat = 3'd1;
    m_cnt = 0;
    m_halt = 0;
    check("reset.vec", 64'(dut_vec), 64'(exp_vec(7, 4'h0)));
    check_state("reset");
    step();
    check("idle_hold.vec", 64'(dut_vec), 64'(exp_vec(7, 4'h0)));
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs one instruction from its FETCH cycle; leaves the bench at the
  // negedge of the following FETCH (or HALT) cycle.
  task automatic run_instr(input logic [3:0] ic, input bit valid, input bit imerr,
                           input int waits, input bit derr, input logic [2:0] flags);
    int  stages[$];
    int  nm;
    int  mk;
    bit  is_mem;
    logic [2:0] fault;
    fault = 3'd0;
    is_mem = (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) ||
             (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
    stages.push_back(0);
    if (imerr) fault = 3'd3;
    else if (!valid) fault = 3'd4;
    else if (ic == 4'h0) fault = 3'd2;
    else begin
      stages.push_back(1);
      stages.push_back(2);
      if (is_mem) begin
        nm = (waits >= T) ? T : waits + 1;
        for (int i = 0; i < nm; i++) stages.push_back(3);
        if (waits >= T || derr) fault = 3'd3;
      end
      if (fault == 3'd0) begin
        stages.push_back(4);
        stages.push_back(5);
      end
    end
    icode = ic;
    instr_valid = valid;
    imem_error = imerr;
    dmem_error = derr;
    {alu_zf, alu_sf, alu_of} = flags;
    mk = 0;
    foreach (stages[i]) begin
      mem_ready = (stages[i] == 3) && (mk >= waits);
      if (stages[i] == 3) mk++;
      check($sformatf("ic%h.cyc%0d", ic, i), 64'(dut_vec), 64'(exp_vec(stages[i], ic)));
      step();
    end
    mem_ready = 1'b0;
    if (ic == 4'h6 && fault == 3'd0) m_cc = flags;
    if (fault != 3'd0) begin
      m_stat = fault;
      m_halt = 1;
    end else begin
      m_cnt++;
    end
    check($sformatf("ic%h.next", ic), 64'(dut_vec), 64'(exp_vec(m_halt ? 6 : 0, ic)));
    check_state($sformatf("ic%h", ic));
    $display("instr icode=%h valid=%0b imerr=%0b waits=%0d derr=%0b -> cc=%b stat=%0d count=%0d halted=%0b",
             ic, valid, imerr, waits, derr, cc, stat, instr_count, halted);
  endtask

  initial begin
    // OPq then jump: cc update only on OPq
    do_reset();
    do_start();
    run_instr(4'h6, 1, 0, 0, 0, 3'b010);
    run_instr(4'h7, 1, 0, 0, 0, 3'b111);
    // Memory read with three wait cycles, then a plain write
    run_instr(4'h5, 1, 0, 3, 0, 3'b000);
    run_instr(4'hA, 1, 0, 0, 0, 3'b000);
    // Ready on the very cycle the timeout would fire
    run_instr(4'h9, 1, 0, T - 1, 0, 3'b000);
    // Write that never completes -> timeout
    run_instr(4'h8, 1, 0, 100, 0, 3'b000);
    step();
    check("halt_hold.vec", 64'(dut_vec), 64'(exp_vec(6, 4'h0)));
    check_state("halt_hold");
    // Data fault
    do_reset();
    do_start();
    run_instr(4'h5, 1, 0, 0, 1, 3'b000);
    // Fetch faults
    do_reset();
    do_start();
    run_instr(4'h1, 1, 0, 0, 0, 3'b000);
    run_instr(4'h0, 1, 0, 0, 0, 3'b000);
    do_reset();
    do_start();
    run_instr(4'h3, 0, 0, 0, 0, 3'b000);
    do_reset();
    do_start();
    run_instr(4'h3, 0, 1, 0, 0, 3'b000);
    // Reset pulsed during a memory wait
    do_reset();
    do_start();
    run_instr(4'h6, 1, 0, 0, 0, 3'b001);
    icode = 4'h5;
    instr_valid = 1'b1;
    imem_error = 1'b0;
    dmem_error = 1'b0;
    mem_ready = 1'b0;
    repeat (5) step();
    check("midrst.pre", 64'(dut_vec), 64'(exp_vec(3, 4'h5)));
    do_reset();
    do_start();
    run_instr(4'h2, 1, 0, 0, 0, 3'b000);
    // Randomized programs
    for (int p = 0; p < 30; p++) begin
      do_reset();
      do_start();
      for (int k = 0; k < 8 && !m_halt; k++) begin
        logic [3:0] ic;
        ic = 4'($urandom_range(0, 11));
        if (ic == 4'h0 && $urandom_range(0, 3) != 0) ic = 4'h1;
        run_instr(ic, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                  int'($urandom_range(0, 10)), $urandom_range(0, 9) == 0,
                  3'($urandom_range(0, 7)));
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_stage_controller.md
Name: seq_stage_controller

Overview:
- Multi-cycle sequencer for the Y86-64 SEQ datapath. Steps one instruction at a time through fetch, decode, execute, memory, writeback and PC update by raising one stage enable per cycle.
- Owns the condition-code register (updated from the execute-stage ALU flags on OPq), the processor status register, and the retired-instruction counter.
- Handles data-memory wait states with a timeout.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent in MEMORY waiting for mem_ready before an ADR fault.
- CNT_W, 32: width of instr_count.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin execution; sampled only in IDLE.
- icode  in  4  instruction code from fetch; sampled at end of FETCH.
- instr_valid  in  1  fetch decoded a legal icode/ifun; sampled at end of FETCH.
- imem_error  in  1  instruction address fault; sampled at end of FETCH.
- alu_zf  in  1  zero flag from execute.
- alu_sf  in  1  sign flag from execute.
- alu_of  in  1  overflow flag from execute.
- mem_ready  in  1  data memory has completed the access.
- dmem_error  in  1  data address fault; valid only when mem_ready=1.
- fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en  out  1 each  stage enables, one-hot or all zero.
- mem_read  out  1  memory read strobe; asserted in MEMORY for icode 5, 9, B.
- mem_write  out  1  memory write strobe; asserted in MEMORY for icode 4, 8, A.
- set_cc  out  1  high in EXECUTE when the latched icode is 6.
- cc  out  3  {ZF,SF,OF}.
- stat  out  3  1 = AOK, 2 = HLT, 3 = ADR, 4 = INS.
- halted  out  1  high in HALT.
- busy  out  1  high in any state other than IDLE or HALT.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset (synchronous, any state, including mid-instruction):
  - state = IDLE; all enables and strobes = 0.
  - cc = 3'b100; stat = 1; instr_count = 0; timeout counter = 0; icode_q = 0.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT. Outputs are Moore-decoded from state and icode_q.
- IDLE: go to FETCH when start=1, else stay.
- FETCH: fetch_en=1. On exit, latch icode into icode_q, then take the first matching branch in this priority order:
  - imem_error → stat=3, HALT.
  - !instr_valid → stat=4, HALT.
  - icode==0 → stat=2, HALT.
  - otherwise → DECODE.
- DECODE: decode_en=1. Next state EXECUTE.
- EXECUTE: execute_en=1.
  - If icode_q==6: set_cc=1 and cc <= {alu_zf, alu_sf, alu_of} at the cycle end. Any other icode leaves cc unchanged.
  - Next state is MEMORY if icode_q is in {4, 5, 8, 9, A, B}, else WRITEBACK.
- MEMORY: memory_en=1; mem_read or mem_write per the icode_q lists above. The timeout counter increments every cycle while mem_ready=0.
  - mem_ready=1 and dmem_error=0 → WRITEBACK; counter cleared.
  - mem_ready=1 and dmem_error=1 → stat=3, HALT.
  - Counter reaches MEM_TIMEOUT with mem_ready=0 → stat=3, HALT.
  - mem_ready=1 on the same cycle the timeout would fire → mem_ready wins.
- WRITEBACK: writeback_en=1. Next state PCUPD.
- PCUPD: pc_en=1; instr_count increments, wrapping modulo 2^CNT_W. Next state FETCH.
- HALT: all enables 0; halted=1; stat and cc hold. Leaves only on rst.
- Latency: 5 cycles per non-memory instruction, 6 + wait cycles per memory instruction.

Decomposition:
- Shared package y86_pkg:
  - icode constants: HALT=0, NOP=1, CMOV=2, IRMOV=3, RMMOV=4, MRMOV=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSH=A, POP=B.
  - stat constants: AOK, HLT, ADR, INS.
  - stage-state enum.
  - Memory-class decode helpers: is_mem_read, is_mem_write.
- One sub-module, mem_wait_timer: counter with clear, enable and timeout flag, parameterised by MEM_TIMEOUT.

Test Plan:
- OPq timing and cc update: rst, then start=1 with icode=6, alu flags {0,1,0}.
  - Required: fetch_en, decode_en, execute_en, writeback_en, pc_en on 5 consecutive cycles.
  - Required: cc=3'b010 after EXECUTE; instr_count=1; next cycle fetch_en=1.
- No cc update on jump: icode=7 after the scenario above → cc stays 3'b010; set_cc never asserted.
- Memory wait: icode=5 with mem_ready low for 3 cycles, then high → memory_en and mem_read high for 4 cycles, then writeback_en; mem_write stays 0.
- Timeout and data fault:
  - MEM_TIMEOUT=8, icode=8, mem_ready held 0 → mem_write for 8 cycles, then stat=3, halted=1.
  - Separately, mem_ready=1 with dmem_error=1 → stat=3.
- Fetch faults:
  - icode=0 → stat=2, halted=1, decode_en never asserted, instr_count unchanged.
  - instr_valid=0 → stat=4.
  - imem_error=1 together with instr_valid=0 → stat=3 (priority).
- Reset mid-operation: rst pulsed during MEMORY wait → next cycle IDLE, all enables 0, cc=3'b100, stat=1, instr_count=0, busy=0; a subsequent start runs normally.
